// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the unified-memory arbiter: sequencer state, requester
// identity, the reset value of the round-robin history, and the two-way
// round-robin pick used at grant time.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    CORE = 1'b0,
    EXT  = 1'b1
  } requester_t;

  // EXT as the last owner out of reset lets the core win the first tie.
  localparam requester_t LAST_RESET = EXT;

  // Round-robin pick. Only called when at least one request is present.
  function automatic requester_t rr_pick(input logic       core_req,
                                         input logic       ext_req,
                                         input requester_t last);
    requester_t pick;
    if (core_req && ext_req) pick = (last == CORE) ? EXT : CORE;
    else if (core_req)       pick = CORE;
    else                     pick = EXT;
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter and access sequencer for the single unified memory.
// One requester is granted per transfer (round-robin on ties); the memory
// enable is held for WAIT_CYCLES cycles, then the owner gets a one-cycle done
// pulse with registered read data.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   core_req/we/addr/wdata          core request (held until core_done)
//   core_done, core_rdata           core completion pulse and read data
//   ext_req/we/addr/wdata           secondary requester (loader / debug)
//   ext_done, ext_rdata             secondary completion pulse and read data
//   mem_en, mem_we                  memory enable and write strobe
//   mem_addr, mem_wdata             memory address and write data
//   mem_rdata                       memory read data (valid on last ACCESS)
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_done,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_done,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WAIT_CYCLES - 1);

  arb_state_t        state_q, state_d;
  requester_t        owner_q, owner_d;
  requester_t        last_q,  last_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= CORE;
      last_q  <= LAST_RESET;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (core_req || ext_req) begin
          owner_d = rr_pick(core_req, ext_req, last_q);
          // Latch the winner's command so the memory side never depends
          // combinationally on the request inputs.
          if (owner_d == CORE) begin
            we_d    = core_we;
            addr_d  = core_addr;
            wdata_d = core_wdata;
          end else begin
            we_d    = ext_we;
            addr_d  = ext_addr;
            wdata_d = ext_wdata;
          end
          cnt_d   = CNT_START;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = mem_rdata;
          last_d  = owner_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs, decoded from registered state only.
  always_comb begin
    mem_en     = (state_q == ACCESS);
    // The counter still holds its start value only on the first ACCESS cycle.
    mem_we     = mem_en && we_q && (cnt_q == CNT_START);
    mem_addr   = mem_en ? addr_q  : '0;
    mem_wdata  = mem_en ? wdata_q : '0;
    core_done  = (state_q == DONE) && (owner_q == CORE);
    ext_done   = (state_q == DONE) && (owner_q == EXT);
    core_rdata = rdata_q;
    ext_rdata  = rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Three arbiter instances (WAIT_CYCLES = 1, 2, 3) share one set of inputs;
// each phase of the run selects one instance to observe. A transaction-level
// model (current transfer, its age in cycles, last owner, captured read data)
// predicts every output per cycle from the applied inputs.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_v   [2];
  logic        we_v    [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [31:0] mem_rdata;

  logic        core_req, core_we, ext_req, ext_we;
  logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata;

  assign core_req   = req_v[0];
  assign core_we    = we_v[0];
  assign core_addr  = addr_v[0];
  assign core_wdata = wdata_v[0];
  assign ext_req    = req_v[1];
  assign ext_we     = we_v[1];
  assign ext_addr   = addr_v[1];
  assign ext_wdata  = wdata_v[1];

  logic        o_core_done  [NDUT];
  logic [31:0] o_core_rdata [NDUT];
  logic        o_ext_done   [NDUT];
  logic [31:0] o_ext_rdata  [NDUT];
  logic        o_mem_en     [NDUT];
  logic        o_mem_we     [NDUT];
  logic [31:0] o_mem_addr   [NDUT];
  logic [31:0] o_mem_wdata  [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .WAIT_CYCLES (g + 1)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_done  (o_core_done[g]),
      .core_rdata (o_core_rdata[g]),
      .ext_req    (ext_req),
      .ext_we     (ext_we),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
      .ext_done   (o_ext_done[g]),
      .ext_rdata  (o_ext_rdata[g]),
      .mem_en     (o_mem_en[g]),
      .mem_we     (o_mem_we[g]),
      .mem_addr   (o_mem_addr[g]),
      .mem_wdata  (o_mem_wdata[g]),
      .mem_rdata  (mem_rdata)
    );
  end

  int n_vec = 0;
  int n_err = 0;
  int sel;
  int wait_n;

  // Reference model: one transfer in flight, t = cycles since its grant edge.
  bit          m_active;
  int          m_t;
  int          m_owner;   // 0 = core, 1 = ext
  int          m_last;
  bit          m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;

  // Requester agents.
  bit pending [2];
  bit auto_mode;
  int req_pct;
  bit rdata_fixed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s (WAIT=%0d, t=%0t): got 0x%08h, want 0x%08h", tag, wait_n, $time, obs, exp_v);
    end
  endtask

  function automatic bit exp_done(input int r);
    return m_active && (m_t == wait_n) && (m_owner == r);
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_t      = 0;
    m_last   = 1;
    m_rdata  = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else if (m_active) begin
      m_t++;
      if (m_t == wait_n) begin
        if (!m_we) m_rdata = mem_rdata;
        m_last = m_owner;
      end else if (m_t == wait_n + 1) begin
        m_active = 1'b0;
      end
    end else if (req_v[0] || req_v[1]) begin
      if (req_v[0] && req_v[1]) m_owner = 1 - m_last;
      else                      m_owner = req_v[0] ? 0 : 1;
      m_active = 1'b1;
      m_t      = 0;
      m_we     = we_v[m_owner];
      m_addr   = addr_v[m_owner];
      m_wdata  = wdata_v[m_owner];
    end
  endtask

  task automatic compare();
    bit en_x;
    en_x = m_active && (m_t < wait_n);
    check("mem_en",    32'(o_mem_en[sel]),    32'(en_x));
    check("mem_we",    32'(o_mem_we[sel]),    32'(en_x && m_we && (m_t == 0)));
    check("core_done", 32'(o_core_done[sel]), 32'(exp_done(0)));
    check("ext_done",  32'(o_ext_done[sel]),  32'(exp_done(1)));
    if (en_x) begin
      check("mem_addr",  o_mem_addr[sel],  m_addr);
      check("mem_wdata", o_mem_wdata[sel], m_wdata);
    end
    if (exp_done(0)) check("core_rdata", o_core_rdata[sel], m_rdata);
    if (exp_done(1)) check("ext_rdata",  o_ext_rdata[sel],  m_rdata);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mem_en"},     32'(o_mem_en[sel]),    32'd0);
    check({tag, ".mem_we"},     32'(o_mem_we[sel]),    32'd0);
    check({tag, ".mem_addr"},   o_mem_addr[sel],       32'd0);
    check({tag, ".mem_wdata"},  o_mem_wdata[sel],      32'd0);
    check({tag, ".core_done"},  32'(o_core_done[sel]), 32'd0);
    check({tag, ".ext_done"},   32'(o_ext_done[sel]),  32'd0);
    check({tag, ".core_rdata"}, o_core_rdata[sel],     32'd0);
    check({tag, ".ext_rdata"},  o_ext_rdata[sel],      32'd0);
  endtask

  // Requesters react to the predicted done pulse, so stimulus never waits on
  // the DUT and the run length is fixed.
  task automatic drive();
    for (int r = 0; r < 2; r++) begin
      if (pending[r] && exp_done(r)) pending[r] = 1'b0;
      if (!pending[r] && auto_mode && ($urandom_range(99) < req_pct)) begin
        pending[r] = 1'b1;
        we_v[r]    = 1'($urandom_range(1));
        addr_v[r]  = $urandom;
        wdata_v[r] = $urandom;
      end
      req_v[r] = pending[r];
    end
    if (!rdata_fixed) mem_rdata = $urandom;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic issue(input int r, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    pending[r] = 1'b1;
    req_v[r]   = 1'b1;
    we_v[r]    = we;
    addr_v[r]  = addr;
    wdata_v[r] = wdata;
  endtask

  task automatic begin_phase(input int s);
    sel       = s;
    wait_n    = s + 1;
    auto_mode = 1'b0;
    reset     = 1'b1;
    for (int r = 0; r < 2; r++) begin
      pending[r] = 1'b0;
      req_v[r]   = 1'b0;
    end
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    sel         = 0;
    wait_n      = 1;
    auto_mode   = 1'b0;
    req_pct     = 0;
    rdata_fixed = 1'b0;
    mem_rdata   = '0;
    for (int r = 0; r < 2; r++) begin
      pending[r] = 1'b0;
      req_v[r]   = 1'b0;
      we_v[r]    = 1'b0;
      addr_v[r]  = '0;
      wdata_v[r] = '0;
    end
    model_reset();
    #2;
    check_all_zero("por");

    // Single core read, fixed memory data.
    begin_phase(0);
    rdata_fixed = 1'b1;
    mem_rdata   = 32'hDEAD_BEEF;
    issue(0, 1'b0, 32'h10, 32'h0);
    run(4);
    rdata_fixed = 1'b0;

    // Simultaneous core write and ext read out of reset: core first.
    begin_phase(0);
    issue(0, 1'b1, 32'h20, 32'h1234);
    issue(1, 1'b0, 32'h40, 32'h0);
    run(8);

    // Both requesters hold requests continuously: grants alternate.
    begin_phase(0);
    auto_mode = 1'b1;
    req_pct   = 100;
    run(18);
    auto_mode = 1'b0;
    run(8);

    // WAIT_CYCLES=3 ext read, core request arrives mid-transfer.
    begin_phase(2);
    issue(1, 1'b0, 32'h0000_0C00, 32'h0);
    run(2);
    issue(0, 1'b1, 32'h0000_0C04, 32'hA5A5_5A5A);
    run(12);

    // Reset during the second ACCESS cycle, then the request is reissued.
    begin_phase(2);
    issue(0, 1'b0, 32'h80, 32'h0);
    run(2);
    reset = 1'b1;
    model_reset();
    #1;
    check_all_zero("mid_reset");
    run(1);
    reset = 1'b0;
    run(8);

    // WAIT_CYCLES=2: a read, then a write that must leave read data intact.
    begin_phase(1);
    issue(0, 1'b0, 32'h100, 32'h0);
    run(5);
    issue(0, 1'b1, 32'h104, 32'hCAFE_F00D);
    run(6);

    // Randomized traffic on every instance.
    for (int s = 0; s < NDUT; s++) begin
      begin_phase(s);
      auto_mode = 1'b1;
      req_pct   = 40;
      run(400);
      auto_mode = 1'b0;
      run(10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
